// File: rtl/de2_115_sdram_pkg.sv
// -----------------------------------------------------------------------------
// de2_115_sdram_pkg
// Shared definitions for the DE2-115 SDRAM init sequencer and the SDRAM
// controller that takes over the command bus afterwards.
//   - 4-bit SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - init sequencer state encoding
//   - helper to turn a wait length T into the wait-timer load value T-1
// -----------------------------------------------------------------------------
package de2_115_sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PWRUP     = 4'd1,
        ST_PRE       = 4'd2,
        ST_WAIT_RP   = 4'd3,
        ST_REF       = 4'd4,
        ST_WAIT_RFC  = 4'd5,
        ST_LMR       = 4'd6,
        ST_WAIT_MRD  = 4'd7,
        ST_DONE      = 4'd8,
        ST_PREF      = 4'd9,
        ST_WAIT_PRFC = 4'd10
    } init_state_e;

    // The timer counts T-1 .. 0, giving exactly T cycles in the wait state.
    function automatic logic [15:0] wait_load(input int unsigned cycles);
        return 16'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/de2_115_wait_timer.sv
// -----------------------------------------------------------------------------
// de2_115_wait_timer
// 16-bit loadable down-counter that stops at zero.
// Ports:
//   i_brd_clk   clock
//   i_brd_rst   asynchronous active-high reset
//   i_clr       synchronous clear (highest priority)
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   o_zero      counter currently reads zero
// -----------------------------------------------------------------------------
module de2_115_wait_timer (
    input  logic        i_brd_clk,
    input  logic        i_brd_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_zero
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear, load, or decrement until zero.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = 16'd0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
        if (i_brd_rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == 16'd0);

endmodule

// File: rtl/de2_115_sdram_init_seq.sv
// -----------------------------------------------------------------------------
// de2_115_sdram_init_seq
// Power-up sequencer for the DE2-115 SDRAM. After PLL lock and the SDRAM
// enable timeout it raises CKE, waits, issues PRECHARGE ALL, REFRESH_COUNT x
// AUTO REFRESH and LOAD MODE REGISTER, then flags o_memory_initialized and
// hands the command bus over (o_init_active=0).
// Ports:
//   i_brd_clk, i_brd_rst        clock, async active-high reset
//   i_pll_locked, i_sdr_ena     start conditions (lock loss restarts)
//   o_cke, o_cmd, o_addr, o_ba  SDRAM control, all registered
//   o_init_active               1 = this block owns the command bus
//   o_memory_initialized        init sequence complete
//   o_ref_active                periodic refresh in progress
// Optional build macro DE2_SDRAM_PERIODIC_REFRESH_EN: after init, issue an
// AUTO REFRESH every REF_INTERVAL cycles, taking the bus back meanwhile.
// Without it o_ref_active is tied low and refresh belongs downstream.
// -----------------------------------------------------------------------------
module de2_115_sdram_init_seq
    import de2_115_sdram_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES  = 8000,
    parameter int unsigned TRP_CYCLES    = 2,
    parameter int unsigned TRFC_CYCLES   = 7,
    parameter int unsigned TMRD_CYCLES   = 2,
    parameter int unsigned REFRESH_COUNT = 8,
    parameter logic [12:0] MODE_REG      = 13'h033
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
    ,
    parameter int unsigned REF_INTERVAL  = 624
`endif
) (
    input  logic        i_brd_clk,
    input  logic        i_brd_rst,
    input  logic        i_pll_locked,
    input  logic        i_sdr_ena,
    output logic        o_cke,
    output logic [3:0]  o_cmd,
    output logic [12:0] o_addr,
    output logic [1:0]  o_ba,
    output logic        o_init_active,
    output logic        o_memory_initialized,
    output logic        o_ref_active
);

    localparam logic [3:0] REF_TARGET = 4'(REFRESH_COUNT);

    init_state_e state_q;
    logic [3:0]  ref_cnt_q;
    logic        cke_q;
    logic [3:0]  cmd_q;
    logic [12:0] addr_q;
    logic [1:0]  ba_q;
    logic        init_active_q;
    logic        mem_init_q;

    logic        lock_lost_s;
    logic        timer_clr_s;
    logic        timer_load_s;
    logic [15:0] timer_val_s;
    logic        timer_zero_s;

    // Losing lock anywhere past IDLE (DONE included) aborts to IDLE.
    assign lock_lost_s = (state_q != ST_IDLE) && !i_pll_locked;

    // Timer control: load T-1 on the edge a command (or CKE rise) is issued.
    always_comb begin
        timer_clr_s  = 1'b0;
        timer_load_s = 1'b0;
        timer_val_s  = 16'd0;
        if (lock_lost_s) begin
            timer_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_pll_locked && i_sdr_ena) begin
                        timer_load_s = 1'b1;
                        timer_val_s  = wait_load(PWRUP_CYCLES);
                    end else begin
                        timer_load_s = 1'b0;
                    end
                end
                ST_PRE: begin
                    timer_load_s = 1'b1;
                    timer_val_s  = wait_load(TRP_CYCLES);
                end
                ST_REF: begin
                    timer_load_s = 1'b1;
                    timer_val_s  = wait_load(TRFC_CYCLES);
                end
                ST_LMR: begin
                    timer_load_s = 1'b1;
                    timer_val_s  = wait_load(TMRD_CYCLES);
                end
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
                ST_WAIT_MRD, ST_WAIT_PRFC: begin
                    // Leaving for DONE starts the refresh interval.
                    if (timer_zero_s) begin
                        timer_load_s = 1'b1;
                        timer_val_s  = wait_load(REF_INTERVAL);
                    end else begin
                        timer_load_s = 1'b0;
                    end
                end
                ST_PREF: begin
                    timer_load_s = 1'b1;
                    timer_val_s  = wait_load(TRFC_CYCLES);
                end
`endif
                default: begin
                    timer_load_s = 1'b0;
                end
            endcase
        end
    end

    de2_115_wait_timer u_wait_timer (
        .i_brd_clk  (i_brd_clk),
        .i_brd_rst  (i_brd_rst),
        .i_clr      (timer_clr_s),
        .i_load     (timer_load_s),
        .i_load_val (timer_val_s),
        .o_zero     (timer_zero_s)
    );

`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
    logic ref_active_q;
    assign o_ref_active = ref_active_q;
`else
    assign o_ref_active = 1'b0;
`endif

    // Sequencer FSM with registered command bus; commands last one cycle.
    always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
        if (i_brd_rst || lock_lost_s) begin
            // Async reset and lock loss share the same idle values.
            state_q       <= ST_IDLE;
            ref_cnt_q     <= 4'd0;
            cke_q         <= 1'b0;
            cmd_q         <= CMD_INHIBIT;
            addr_q        <= 13'd0;
            ba_q          <= 2'd0;
            init_active_q <= 1'b1;
            mem_init_q    <= 1'b0;
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
            ref_active_q  <= 1'b0;
`endif
        end else begin
            cmd_q  <= CMD_NOP;
            addr_q <= 13'd0;
            ba_q   <= 2'd0;
            case (state_q)
                ST_IDLE: begin
                    if (i_pll_locked && i_sdr_ena) begin
                        state_q <= ST_PWRUP;
                        cke_q   <= 1'b1;
                    end else begin
                        cmd_q   <= CMD_INHIBIT;
                    end
                end
                ST_PWRUP: begin
                    if (timer_zero_s) begin
                        state_q <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    cmd_q   <= CMD_PRECHARGE;
                    addr_q  <= 13'h0400;    // A10=1: all banks
                    state_q <= ST_WAIT_RP;
                end
                ST_WAIT_RP: begin
                    if (timer_zero_s) begin
                        state_q <= ST_REF;
                    end
                end
                ST_REF: begin
                    cmd_q     <= CMD_AUTO_REFRESH;
                    ref_cnt_q <= ref_cnt_q + 4'd1;
                    state_q   <= ST_WAIT_RFC;
                end
                ST_WAIT_RFC: begin
                    if (timer_zero_s) begin
                        state_q <= (ref_cnt_q < REF_TARGET) ? ST_REF : ST_LMR;
                    end
                end
                ST_LMR: begin
                    cmd_q   <= CMD_LOAD_MODE;
                    addr_q  <= MODE_REG;
                    state_q <= ST_WAIT_MRD;
                end
                ST_WAIT_MRD: begin
                    if (timer_zero_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mem_init_q <= 1'b1;
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
                    if (timer_zero_s) begin
                        // Reclaim the bus one cycle ahead of the refresh.
                        ref_active_q  <= 1'b1;
                        init_active_q <= 1'b1;
                        state_q       <= ST_PREF;
                    end else begin
                        init_active_q <= 1'b0;
                    end
`else
                    init_active_q <= 1'b0;
`endif
                end
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
                ST_PREF: begin
                    cmd_q   <= CMD_AUTO_REFRESH;
                    state_q <= ST_WAIT_PRFC;
                end
                ST_WAIT_PRFC: begin
                    if (timer_zero_s) begin
                        ref_active_q  <= 1'b0;
                        init_active_q <= 1'b0;
                        state_q       <= ST_DONE;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cke                = cke_q;
    assign o_cmd                = cmd_q;
    assign o_addr               = addr_q;
    assign o_ba                 = ba_q;
    assign o_init_active        = init_active_q;
    assign o_memory_initialized = mem_init_q;

endmodule

// File: tb/tb_de2_115_sdram_init_seq.sv
// -----------------------------------------------------------------------------
// tb_de2_115_sdram_init_seq
// Directed bench for de2_115_sdram_init_seq with shortened timings
// (PWRUP=4, TRP=2, TRFC=3, TMRD=2, REFRESH_COUNT=2; REF_INTERVAL=10 when
// DE2_SDRAM_PERIODIC_REFRESH_EN is defined). Cycle 0 is the first clock edge
// that samples lock & enable high.
// -----------------------------------------------------------------------------
module tb_de2_115_sdram_init_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic        ena;
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        init_active;
    logic        mem_init;
    logic        ref_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    de2_115_sdram_init_seq #(
        .PWRUP_CYCLES  (4),
        .TRP_CYCLES    (2),
        .TRFC_CYCLES   (3),
        .TMRD_CYCLES   (2),
        .REFRESH_COUNT (2),
        .MODE_REG      (13'h033)
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
        ,
        .REF_INTERVAL  (10)
`endif
    ) dut (
        .i_brd_clk            (clk),
        .i_brd_rst            (rst),
        .i_pll_locked         (lock),
        .i_sdr_ena            (ena),
        .o_cke                (cke),
        .o_cmd                (cmd),
        .o_addr               (addr),
        .o_ba                 (ba),
        .o_init_active        (init_active),
        .o_memory_initialized (mem_init),
        .o_ref_active         (ref_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"},  32'(cmd),         32'hF);
        chk({tag, "_cke"},  32'(cke),         32'h0);
        chk({tag, "_addr"}, 32'(addr),        32'h0);
        chk({tag, "_ba"},   32'(ba),          32'h0);
        chk({tag, "_ia"},   32'(init_active), 32'h1);
        chk({tag, "_mi"},   32'(mem_init),    32'h0);
        chk({tag, "_ra"},   32'(ref_active),  32'h0);
    endtask

    // Hand-derived command timeline for the shortened init sequence.
    function automatic logic [3:0] exp_cmd(input int k);
        case (k)
            5:       return 4'b0010;
            8, 12:   return 4'b0001;
            16:      return 4'b0000;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [12:0] exp_addr(input int k);
        case (k)
            5:       return 13'h0400;
            16:      return 13'h0033;
            default: return 13'h0000;
        endcase
    endfunction

    // Raise lock (enable already high) and check cycles 0..last.
    task automatic check_seq(input int last, input string pfx);
        lock = 1'b1;
        for (int k = 0; k <= last; k++) begin
            step();
            chk($sformatf("%s_cmd_c%0d", pfx, k),  32'(cmd),         32'(exp_cmd(k)));
            chk($sformatf("%s_addr_c%0d", pfx, k), 32'(addr),        32'(exp_addr(k)));
            chk($sformatf("%s_ba_c%0d", pfx, k),   32'(ba),          32'h0);
            chk($sformatf("%s_cke_c%0d", pfx, k),  32'(cke),         32'h1);
            chk($sformatf("%s_mi_c%0d", pfx, k),   32'(mem_init),    (k >= 19) ? 32'h1 : 32'h0);
            chk($sformatf("%s_ia_c%0d", pfx, k),   32'(init_active), (k >= 19) ? 32'h0 : 32'h1);
        end
    endtask

    // Protocol monitor: minimum NOP gap after each command, PRECHARGE uses A10.
    int         nop_run  = 0;
    int         prev_req = 0;
    logic       have_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst && !$isunknown(cmd)) begin
            if (cmd == 4'b1111) begin
                have_prev = 1'b0;
                nop_run   = 0;
            end else if (cmd == 4'b0111) begin
                nop_run++;
            end else begin
                if (have_prev) begin
                    chk("proto_gap", (nop_run >= prev_req) ? 32'h1 : 32'h0, 32'h1);
                end
                if (cmd == 4'b0010) begin
                    chk("proto_pre_a10", 32'(addr[10]), 32'h1);
                end
                prev_req  = (cmd == 4'b0001) ? 3 : 2;
                have_prev = 1'b1;
                nop_run   = 0;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        lock = 1'b0;
        ena  = 1'b0;
        #12;
        chk_reset("reset");
        step();
        rst = 1'b0;

        // Lock without enable: bus must stay inhibited.
        lock = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("noena_cmd_%0d", k), 32'(cmd), 32'hF);
            chk($sformatf("noena_cke_%0d", k), 32'(cke), 32'h0);
        end

        ena = 1'b1;
        check_seq(19, "seq1");

        // Post-init behaviour, cycles 20..45.
        for (int k = 20; k <= 45; k++) begin
            step();
`ifdef DE2_SDRAM_PERIODIC_REFRESH_EN
            chk($sformatf("post_cmd_c%0d", k), 32'(cmd),
                (k == 29 || k == 43) ? 32'h1 : 32'h7);
            chk($sformatf("post_ra_c%0d", k), 32'(ref_active),
                ((k >= 28 && k <= 31) || k >= 42) ? 32'h1 : 32'h0);
            chk($sformatf("post_ia_c%0d", k), 32'(init_active),
                ((k >= 28 && k <= 31) || k >= 42) ? 32'h1 : 32'h0);
`else
            chk($sformatf("post_cmd_c%0d", k), 32'(cmd),         32'h7);
            chk($sformatf("post_ra_c%0d", k),  32'(ref_active),  32'h0);
            chk($sformatf("post_ia_c%0d", k),  32'(init_active), 32'h0);
`endif
            chk($sformatf("post_mi_c%0d", k), 32'(mem_init), 32'h1);
        end

        // Lock loss while done.
        lock = 1'b0;
        step();
        chk_reset("lockloss_done");
        step();
        chk_reset("lockloss_hold");

        // Abort during the second refresh wait, then rerun from scratch.
        check_seq(13, "seq2");
        lock = 1'b0;
        step();
        chk_reset("lockloss_rfc");
        step();
        step();
        check_seq(19, "seq3");

        // Asynchronous reset in the power-up wait.
        lock = 1'b0;
        step();
        chk_reset("pre_seq4");
        check_seq(2, "seq4");
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step();
        step();
        rst = 1'b0;
        check_seq(19, "seq5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
